seq_encoder_32x5: RTL
=====================

Name: seq_encoder_32x5

Overview:
- Sequential 32-to-5 priority encoder; the encode-side counterpart to the team's 5x32 decoder.
- Accepts a 32-bit request vector with a valid/ready handshake and captures it.
- Emits the 5-bit index of each set bit, one per output handshake, lowest index first, clearing each bit as it is served.
- Sits between request-collection logic (interrupt lines, grant masks) and consumers that drive a 5x32 decoder.

Parameters:
- SEL_W, 5, index width. Input vector width is 2**SEL_W (32 at default). Count width is SEL_W+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  global enable; low freezes all state
- req_valid  input  1  request vector valid
- req  input  32  request vector, bit i = request for index i
- req_ready  output  1  block can capture a new vector
- A  output  5  encoded index of the currently presented request
- out_valid  output  1  A is valid
- out_ready  input  1  consumer accepts A
- count  output  6  set bits remaining, including the one presented (0..32)
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Reset values, applied on the rst=1 clock edge regardless of enable:
  - pend=0, A=0, out_valid=0, count=0, zero_err=0, state=IDLE
  - Reset mid-SERVE discards all pending bits.
- States: IDLE, SERVE.
- IDLE:
  - req_ready = enable.
  - Accept on req_valid & req_ready at edge N.
  - If req != 0: pend<=req, A<=priority(req), count<=popcount(req), out_valid<=1 at N+1, go to SERVE. Latency is exactly 1 cycle.
  - If req == 0: zero_err=1 for cycle N+1 only; stay IDLE; nothing is emitted.
- SERVE:
  - req_ready=0. New vectors are not merged and req is ignored.
  - On out_valid & out_ready & enable at edge M:
    - pend_next = pend & ~(1<<A)
    - A <= priority(pend_next), count <= count-1
  - If pend_next != 0: stay in SERVE with out_valid=1 at M+1. Full throughput is one index per cycle while out_ready is held high.
  - If pend_next == 0: out_valid<=0, A<=0, count<=0, go to IDLE. req_ready is high at M+1.
  - A, count and pend are stable while out_valid=1 and out_ready=0.
- priority(): lowest set bit index by default.
- All outputs (A, out_valid, count, zero_err) are registered. The only combinational gating is:
  - req_ready = (state==IDLE) & enable
  - out_valid port = vld_reg & enable
- enable=0:
  - No capture, no handshake, no state/count change.
  - out_valid and req_ready read 0. Registers hold their values.
  - Outputs resume unchanged when enable returns to 1.
- Boundaries:
  - req=32'hFFFFFFFF yields 32 consecutive indices 0..31 with count 32 down to 1, then IDLE.
  - Single-bit req yields exactly one output, then IDLE.
  - A return to IDLE and a new capture cannot occur in the same cycle; the minimum gap is 1 cycle.

Optional Feature:
- Macro: ENC_MSB_FIRST_EN
- Defined: priority() selects the highest set bit, so serve order is 31 down to 0. All handshake, latency and count rules are unchanged.
- Undefined: lowest set bit first, as described above.

Test Plan:
- Reset then req=32'h0000_0001, req_valid 1 cycle, out_ready=1 -> out_valid next cycle with A=0, count=1. Following cycle out_valid=0 and req_ready=1.
- req=32'h8000_0011, out_ready=1 -> A sequence 0,4,31 on three consecutive cycles with count 3,2,1, then IDLE.
- req=32'hFFFF_FFFF, out_ready toggled 1,0,1,... -> A advances only on ready cycles, A/count hold on stall cycles. All 32 indices are emitted in order, and req_valid is ignored while in SERVE.
- req=32'h0 accepted -> zero_err=1 for exactly one cycle, out_valid stays 0, req_ready stays 1.
- During SERVE of 32'h0000_00F0, drop enable for 5 cycles -> out_valid=0 and A frozen at 5. After re-enable, A continues 5,6,7. Assert rst mid-sequence -> next cycle out_valid=0, count=0, A=0, req_ready=1.
- ENC_MSB_FIRST_EN defined, req=32'h8000_0011 -> A sequence 31,4,0.

Source files
------------

// File: rtl/seq_encoder_32x5.sv
// seq_encoder_32x5: sequential 32-to-5 priority encoder.
// Captures a request vector over a valid/ready handshake, then presents the
// index of each set bit, one per output handshake, clearing each bit as it is
// served. Lowest index first by default.
// Optional build macro: ENC_MSB_FIRST_EN (serve highest set bit first).
module seq_encoder_32x5 #(
    parameter int SEL_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  req_valid,
    input  logic [2**SEL_W-1:0]   req,
    output logic                  req_ready,
    output logic [SEL_W-1:0]      A,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W:0]        count,
    output logic                  zero_err
);

    localparam int N = 2**SEL_W;

    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

    state_t          state, state_n;
    logic [N-1:0]    pend, pend_n, pend_clr;
    logic [SEL_W-1:0] a_reg, a_n;
    logic            vld_reg, vld_n;
    logic [SEL_W:0]  count_reg, count_n;
    logic            zerr_reg, zerr_n;

    // Index of the set bit that is served next.
    function automatic logic [SEL_W-1:0] prio(input logic [N-1:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++)
            if (v[i]) r = i[SEL_W-1:0];
`else
        for (int i = N-1; i >= 0; i--)
            if (v[i]) r = i[SEL_W-1:0];
`endif
        return r;
    endfunction

    // Number of set bits in a vector.
    function automatic logic [SEL_W:0] popcnt(input logic [N-1:0] v);
        logic [SEL_W:0] c;
        c = '0;
        for (int i = 0; i < N; i++)
            c = c + {{SEL_W{1'b0}}, v[i]};
        return c;
    endfunction

    // Pending vector with the currently presented bit removed.
    assign pend_clr = pend & ~({{(N-1){1'b0}}, 1'b1} << a_reg);

    // Next-state and next-output computation; everything holds while enable is low.
    always_comb begin
        state_n = state;
        pend_n  = pend;
        a_n     = a_reg;
        vld_n   = vld_reg;
        count_n = count_reg;
        zerr_n  = zerr_reg;
        if (enable) begin
            zerr_n = 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req != '0) begin
                            pend_n  = req;
                            a_n     = prio(req);
                            count_n = popcnt(req);
                            vld_n   = 1'b1;
                            state_n = SERVE;
                        end else begin
                            zerr_n = 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (vld_reg && out_ready) begin
                        pend_n  = pend_clr;
                        count_n = count_reg - {{SEL_W{1'b0}}, 1'b1};
                        if (pend_clr != '0) begin
                            a_n = prio(pend_clr);
                        end else begin
                            a_n     = '0;
                            count_n = '0;
                            vld_n   = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and output registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            a_reg     <= '0;
            vld_reg   <= 1'b0;
            count_reg <= '0;
            zerr_reg  <= 1'b0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            a_reg     <= a_n;
            vld_reg   <= vld_n;
            count_reg <= count_n;
            zerr_reg  <= zerr_n;
        end
    end

    assign req_ready = (state == IDLE) && enable;
    assign out_valid = vld_reg && enable;
    assign A         = a_reg;
    assign count     = count_reg;
    assign zero_err  = zerr_reg;

endmodule
